// File: rtl/branch_predict_resolve.sv
// ---------------------------------------------------------------------------
// branch_predict_resolve
//
// Branch history table (BHT) of saturating counters shared by fetch-stage
// prediction and execute-stage resolution, plus branch/mispredict counters.
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   fetch_pc            PC being fetched (table index pc[IDX_W+1:2])
//   fetch_pred_taken    MSB of the indexed counter, 0 until the table is ready
//   ready               high once the initialisation sweep has finished
//   res_*               resolving instruction in execute (valid, pc, kind,
//                       funct3, prediction carried down the pipe)
//   cmp_eq/lt/ltu       comparator flags for rs1 vs rs2
//   pc_source           0 next inst, 1 branch offset, 2 ALU result,
//                       3 fall-through (res_pc + 4)
//   flush               squash younger instructions
//   illegal_branch      bad funct3 or branch and jump both asserted
//   branch_count        resolved conditional branches (wraps)
//   mispredict_count    mispredicted conditional branches (wraps)
// ---------------------------------------------------------------------------
module branch_predict_resolve #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_BITS    = 2,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   fetch_pc,
   output logic              fetch_pred_taken,
   output logic              ready,
   input  logic              res_valid,
   input  logic [XLEN-1:0]   res_pc,
   input  logic              res_branch,
   input  logic              res_jump,
   input  logic [2:0]        res_funct3,
   input  logic              res_pred_taken,
   input  logic              cmp_eq,
   input  logic              cmp_lt,
   input  logic              cmp_ltu,
   output logic [1:0]        pc_source,
   output logic              flush,
   output logic              illegal_branch,
   output logic [PERF_W-1:0] branch_count,
   output logic [PERF_W-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
   localparam logic [CTR_BITS-1:0] CTR_MIN     = '0;
   localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(BHT_ENTRIES - 1);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   typedef enum logic [1:0] {
      PC_NEXT_INST     = 2'd0,
      PC_BRANCH_OFFSET = 2'd1,
      PC_ALU_RESULT    = 2'd2,
      PC_FALLTHROUGH   = 2'd3
   } pc_src_e;

   state_e             state_q;
   state_e             state_d;
   logic [IDX_W-1:0]   sweep_idx;

   logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

   logic [IDX_W-1:0]    fetch_idx;
   logic [IDX_W-1:0]    res_idx;
   logic                actual;
   logic                legal_funct3;
   logic                resolved;
   logic                mispredict;
   logic                upd_en;
   logic [CTR_BITS-1:0] upd_ctr;
   pc_src_e             pc_src;

   // Only the index bits of each PC matter; the rest are folded here so the
   // unused bits are visibly accounted for.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                             res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

   assign fetch_idx = fetch_pc[IDX_W+1:2];
   assign res_idx   = res_pc[IDX_W+1:2];

   // ------------------------------------------------------------------
   // FSM: INIT sweeps every entry once, then RUN forever until reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q   <= ST_INIT;
         sweep_idx <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT) begin
            sweep_idx <= sweep_idx + IDX_W'(1);
         end
      end
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      case (state_q)
         ST_INIT: if (sweep_idx == IDX_LAST) state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   assign ready = (state_q == ST_RUN);

   // ------------------------------------------------------------------
   // Resolution: actual outcome, mispredict detection, redirect control.
   // ------------------------------------------------------------------
   always_comb begin
      actual       = 1'b0;
      legal_funct3 = 1'b1;
      case (res_funct3)
         3'b000:  actual = cmp_eq;
         3'b001:  actual = ~cmp_eq;
         3'b100:  actual = cmp_lt;
         3'b101:  actual = ~cmp_lt;
         3'b110:  actual = cmp_ltu;
         3'b111:  actual = ~cmp_ltu;
         default: legal_funct3 = 1'b0;
      endcase
   end

   // A conflicting branch+jump encoding is never treated as a branch.
   assign resolved   = res_valid & res_branch & ~res_jump & legal_funct3;
   assign mispredict = resolved & (actual != res_pred_taken);

   always_comb begin
      pc_src         = PC_NEXT_INST;
      flush          = 1'b0;
      illegal_branch = 1'b0;
      if (res_valid) begin
         if (res_branch && res_jump) begin
            illegal_branch = 1'b1;
         end else if (res_jump) begin
            pc_src = PC_ALU_RESULT;
            flush  = 1'b1;
         end else if (res_branch && !legal_funct3) begin
            illegal_branch = 1'b1;
         end else if (mispredict && actual) begin
            pc_src = PC_BRANCH_OFFSET;
            flush  = 1'b1;
         end else if (mispredict) begin
            pc_src = PC_FALLTHROUGH;
            flush  = 1'b1;
         end
      end
   end

   assign pc_source = pc_src;

   // ------------------------------------------------------------------
   // Table: sweep write in INIT, saturating update in RUN.
   // ------------------------------------------------------------------
   assign upd_en = (state_q == ST_RUN) & resolved;

   always_comb begin
      upd_ctr = bht[res_idx];
      if (actual) begin
         if (bht[res_idx] != CTR_MAX) upd_ctr = bht[res_idx] + CTR_BITS'(1);
      end else begin
         if (bht[res_idx] != CTR_MIN) upd_ctr = bht[res_idx] - CTR_BITS'(1);
      end
   end

   // NOTE: the table storage has no reset term; the INIT sweep is what gives
   // it defined contents, which keeps it mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == ST_INIT) begin
            bht[sweep_idx] <= CTR_WEAK_NT;
         end else if (upd_en) begin
            bht[res_idx] <= upd_ctr;
         end
      end
   end

   // Reads the pre-edge contents, so a same-cycle update to the same index
   // is not bypassed to fetch.
   assign fetch_pred_taken = (state_q == ST_RUN) ? bht[fetch_idx][CTR_BITS-1] : 1'b0;

   // ------------------------------------------------------------------
   // Performance counters, wrapping naturally at 2^PERF_W.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (state_q == ST_RUN) begin
         if (resolved)   branch_count     <= branch_count + PERF_W'(1);
         if (mispredict) mispredict_count <= mispredict_count + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_resolve
//
// Scenario tasks drive the resolve/fetch ports; expected redirect outputs are
// pushed to a scoreboard queue as stimulus is applied and popped when the
// combinational outputs are sampled. A second, small instance (4 entries,
// 4-bit perf counters) covers counter wrap-around.
// ---------------------------------------------------------------------------
module tb_branch_predict_resolve;

   localparam int XLEN = 32;
   localparam int N    = 64;

   typedef struct packed {
      logic [1:0] src;
      logic       fl;
      logic       ill;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_branch = '0;
   logic [31:0] exp_mis    = '0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance
   logic            rst_n = 1'b0;
   logic [XLEN-1:0] fetch_pc = '0;
   logic            fetch_pred_taken;
   logic            ready;
   logic            res_valid = 1'b0;
   logic [XLEN-1:0] res_pc = '0;
   logic            res_branch = 1'b0;
   logic            res_jump = 1'b0;
   logic [2:0]      res_funct3 = '0;
   logic            res_pred_taken = 1'b0;
   logic            cmp_eq = 1'b0;
   logic            cmp_lt = 1'b0;
   logic            cmp_ltu = 1'b0;
   logic [1:0]      pc_source;
   logic            flush;
   logic            illegal_branch;
   logic [31:0]     branch_count;
   logic [31:0]     mispredict_count;

   branch_predict_resolve #(
      .XLEN(XLEN), .BHT_ENTRIES(N), .CTR_BITS(2), .PERF_W(32)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken), .ready(ready),
      .res_valid(res_valid), .res_pc(res_pc), .res_branch(res_branch),
      .res_jump(res_jump), .res_funct3(res_funct3), .res_pred_taken(res_pred_taken),
      .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
      .pc_source(pc_source), .flush(flush), .illegal_branch(illegal_branch),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   // Small instance for wrap-around
   logic            s_rst_n = 1'b0;
   logic [XLEN-1:0] s_fetch_pc = '0;
   logic            s_fetch_pred_taken;
   logic            s_ready;
   logic            s_res_valid = 1'b0;
   logic [XLEN-1:0] s_res_pc = '0;
   logic            s_res_branch = 1'b0;
   logic            s_res_jump = 1'b0;
   logic [2:0]      s_res_funct3 = '0;
   logic            s_res_pred_taken = 1'b0;
   logic            s_cmp_eq = 1'b0;
   logic            s_cmp_lt = 1'b0;
   logic            s_cmp_ltu = 1'b0;
   logic [1:0]      s_pc_source;
   logic            s_flush;
   logic            s_illegal_branch;
   logic [3:0]      s_branch_count;
   logic [3:0]      s_mispredict_count;

   branch_predict_resolve #(
      .XLEN(XLEN), .BHT_ENTRIES(4), .CTR_BITS(2), .PERF_W(4)
   ) dut_small (
      .clk(clk), .rst_n(s_rst_n),
      .fetch_pc(s_fetch_pc), .fetch_pred_taken(s_fetch_pred_taken), .ready(s_ready),
      .res_valid(s_res_valid), .res_pc(s_res_pc), .res_branch(s_res_branch),
      .res_jump(s_res_jump), .res_funct3(s_res_funct3), .res_pred_taken(s_res_pred_taken),
      .cmp_eq(s_cmp_eq), .cmp_lt(s_cmp_lt), .cmp_ltu(s_cmp_ltu),
      .pc_source(s_pc_source), .flush(s_flush), .illegal_branch(s_illegal_branch),
      .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
   );

   // ------------------------------------------------------------------
   // Stimulus primitives
   // ------------------------------------------------------------------

   // One resolve cycle: inputs present across exactly one rising edge.
   task automatic resolve(input string name, input logic [31:0] pc,
                          input logic [2:0] f3, input logic br, input logic jp,
                          input logic pr, input logic eq, input logic lt,
                          input logic ltu, input logic [1:0] e_src,
                          input logic e_fl, input logic e_ill,
                          input logic counted);
      exp_t e;
      exp_t got;
      @(negedge clk);
      res_pc = pc; res_funct3 = f3; res_branch = br; res_jump = jp;
      res_pred_taken = pr; cmp_eq = eq; cmp_lt = lt; cmp_ltu = ltu;
      res_valid = 1'b1;
      e.src = e_src; e.fl = e_fl; e.ill = e_ill;
      sb.push_back(e);
      if (counted) begin
         exp_branch = exp_branch + 1;
         if (e_src == 2'd1 || e_src == 2'd3) exp_mis = exp_mis + 1;
      end
      #1;
      e   = sb.pop_front();
      got = '{src: pc_source, fl: flush, ill: illegal_branch};
      n_checks++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL %s: got src=%0d flush=%b ill=%b, want src=%0d flush=%b ill=%b",
                  name, got.src, got.fl, got.ill, e.src, e.fl, e.ill);
      end
      @(posedge clk);
      #1;
      res_valid = 1'b0; res_branch = 1'b0; res_jump = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      exp_branch = '0;
      exp_mis    = '0;
      n_checks++;
      if ({ready, fetch_pred_taken, pc_source, flush, illegal_branch} !== 6'b0 ||
          branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_values: ready=%b pred=%b src=%0d flush=%b ill=%b bc=%0d mc=%0d, want all 0",
                  ready, fetch_pred_taken, pc_source, flush, illegal_branch,
                  branch_count, mispredict_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Counts rising edges from reset release until ready, bounded.
   task automatic wait_ready(input string name);
      int cycles = 0;
      while (cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
         if (ready) break;
      end
      n_checks++;
      if (cycles != N || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: ready after %0d cycles (ready=%b), want %0d cycles",
                  name, cycles, ready, N);
      end
   endtask

   task automatic check_fetch(input string name, input logic [31:0] pc, input logic want);
      @(negedge clk);
      fetch_pc = pc;
      #1;
      n_checks++;
      if (fetch_pred_taken !== want) begin
         n_fail++;
         $display("FAIL %s: pc=%h pred=%b, want %b", name, pc, fetch_pred_taken, want);
      end
   endtask

   task automatic check_ctr(input string name, input int idx, input logic [1:0] want);
      n_checks++;
      if (dut.bht[idx] !== want) begin
         n_fail++;
         $display("FAIL %s: bht[%0d]=%b, want %b", name, idx, dut.bht[idx], want);
      end
   endtask

   task automatic check_perf(input string name);
      n_checks++;
      if (branch_count !== exp_branch || mispredict_count !== exp_mis) begin
         n_fail++;
         $display("FAIL %s: branch_count=%0d mispredict_count=%0d, want %0d %0d",
                  name, branch_count, mispredict_count, exp_branch, exp_mis);
      end
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      int bad_pred = 0;
      int bad_ctr  = 0;
      do_reset();
      wait_ready("init_sweep_len");
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         fetch_pc = 32'(i * 4);
         #1;
         if (fetch_pred_taken !== 1'b0) bad_pred++;
         if (dut.bht[i] !== 2'b01) bad_ctr++;
      end
      n_checks++;
      if (bad_pred != 0) begin
         n_fail++;
         $display("FAIL init_lookup: %0d entries predict taken, want 0", bad_pred);
      end
      n_checks++;
      if (bad_ctr != 0) begin
         n_fail++;
         $display("FAIL init_counters: %0d entries not 01, want 0", bad_ctr);
      end
      check_perf("perf_after_init");
   endtask

   task automatic test_idle();
      @(negedge clk);
      res_valid = 1'b0; res_branch = 1'b1; res_jump = 1'b1; res_funct3 = 3'b010;
      #1;
      n_checks++;
      if ({pc_source, flush, illegal_branch} !== 4'b0) begin
         n_fail++;
         $display("FAIL idle_outputs: src=%0d flush=%b ill=%b, want 0 0 0",
                  pc_source, flush, illegal_branch);
      end
      res_branch = 1'b0; res_jump = 1'b0; res_funct3 = 3'b000;
   endtask

   task automatic test_saturate();
      check_fetch("pre_update_pred", 32'h100, 1'b0);
      // fetch_pc stays 0x100: during the first update lookup must see old 01.
      @(negedge clk);
      res_pc = 32'h100; res_funct3 = 3'b000; res_branch = 1'b1; res_jump = 1'b0;
      res_pred_taken = 1'b0; cmp_eq = 1'b1; res_valid = 1'b1;
      #1;
      n_checks++;
      if (fetch_pred_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL no_bypass: pred=%b, want 0", fetch_pred_taken);
      end
      res_valid = 1'b0; res_branch = 1'b0;
      resolve("beq_taken_1", 32'h100, 3'b000, 1, 0, 0, 1, 0, 0, 2'd1, 1, 0, 1);
      check_ctr("ctr_after_1", 0, 2'b10);
      check_fetch("pred_after_1", 32'h100, 1'b1);
      resolve("beq_taken_2", 32'h100, 3'b000, 1, 0, 0, 1, 0, 0, 2'd1, 1, 0, 1);
      check_ctr("ctr_after_2", 0, 2'b11);
      resolve("beq_taken_3", 32'h100, 3'b000, 1, 0, 0, 1, 0, 0, 2'd1, 1, 0, 1);
      check_ctr("ctr_saturated", 0, 2'b11);
      check_perf("perf_after_beq");
   endtask

   task automatic test_bne_mispredict();
      resolve("bne_not_taken", 32'h100, 3'b001, 1, 0, 1, 1, 0, 0, 2'd3, 1, 0, 1);
      check_ctr("ctr_after_bne", 0, 2'b10);
      check_perf("perf_after_bne");
   endtask

   task automatic test_signed_unsigned();
      resolve("blt_not_taken", 32'h204, 3'b100, 1, 0, 0, 0, 0, 1, 2'd0, 0, 0, 1);
      check_ctr("ctr_blt", 1, 2'b00);
      resolve("bltu_taken", 32'h208, 3'b110, 1, 0, 0, 0, 0, 1, 2'd1, 1, 0, 1);
      check_ctr("ctr_bltu", 2, 2'b10);
      check_fetch("pred_bltu", 32'h208, 1'b1);
      resolve("bge_mispredict", 32'h20c, 3'b101, 1, 0, 1, 0, 1, 0, 2'd3, 1, 0, 1);
      resolve("bgeu_correct", 32'h210, 3'b111, 1, 0, 1, 0, 0, 0, 2'd0, 0, 0, 1);
      check_ctr("ctr_bgeu", 4, 2'b10);
      check_perf("perf_after_cmp");
   endtask

   task automatic test_jump_illegal();
      resolve("jal", 32'h100, 3'b000, 0, 1, 0, 1, 0, 0, 2'd2, 1, 0, 0);
      check_ctr("jal_table_unchanged", 0, 2'b10);
      resolve("branch_and_jump", 32'h100, 3'b000, 1, 1, 0, 1, 0, 0, 2'd0, 0, 1, 0);
      check_ctr("conflict_table_unchanged", 0, 2'b10);
      resolve("funct3_010", 32'h100, 3'b010, 1, 0, 1, 1, 1, 1, 2'd0, 0, 1, 0);
      resolve("funct3_011", 32'h100, 3'b011, 1, 0, 0, 1, 1, 1, 2'd0, 0, 1, 0);
      check_ctr("illegal_table_unchanged", 0, 2'b10);
      check_perf("perf_after_illegal");
   endtask

   task automatic test_reset_mid_init();
      do_reset();
      // Resolve during INIT: redirect still produced, nothing counted.
      resolve("init_resolve", 32'h100, 3'b000, 1, 0, 0, 1, 0, 0, 2'd1, 1, 0, 0);
      check_fetch("init_pred_zero", 32'h100, 1'b0);
      check_perf("init_no_count");
      repeat (7) @(posedge clk);
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_mid_init: ready=%b, want 0", ready);
      end
      do_reset();
      wait_ready("restart_sweep_len");
      check_ctr("restart_ctr0", 0, 2'b01);
   endtask

   task automatic test_reset_in_run();
      for (int i = 0; i < 5; i++) begin
         resolve("run_beq_correct", 32'h300, 3'b000, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 1);
      end
      check_perf("perf_count_5");
      do_reset();
      wait_ready("run_reset_sweep_len");
      check_perf("perf_after_run_reset");
      check_ctr("run_reset_ctr0", 0, 2'b01);
   endtask

   task automatic test_wrap();
      int cycles = 0;
      @(negedge clk);
      s_rst_n = 1'b1;
      while (cycles < 50 && !s_ready) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      n_checks++;
      if (s_ready !== 1'b1 || cycles != 4) begin
         n_fail++;
         $display("FAIL small_ready: ready=%b after %0d cycles, want 1 after 4",
                  s_ready, cycles);
      end
      @(negedge clk);
      s_res_pc = 32'h0; s_res_funct3 = 3'b000; s_res_branch = 1'b1;
      s_cmp_eq = 1'b1; s_res_pred_taken = 1'b1; s_res_valid = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      n_checks++;
      if (s_branch_count !== 4'd15 || s_mispredict_count !== 4'd0) begin
         n_fail++;
         $display("FAIL small_count_max: bc=%0d mc=%0d, want 15 0",
                  s_branch_count, s_mispredict_count);
      end
      @(posedge clk);
      #1;
      s_res_valid = 1'b0;
      n_checks++;
      if (s_branch_count !== 4'd0) begin
         n_fail++;
         $display("FAIL small_count_wrap: bc=%0d, want 0", s_branch_count);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_saturate();
      test_bne_mispredict();
      test_signed_unsigned();
      test_jump_illegal();
      test_reset_mid_init();
      test_reset_in_run();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
